// File: rtl/layer1_pkg.sv
// Shared defaults and FSM encoding for the layer-1 post-processing block.
package layer1_pkg;

  localparam int LANES_DEF  = 10;
  localparam int LANE_W_DEF = 16;
  localparam int OUT_W_DEF  = 8;
  localparam int SHIFT_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/layer1_act_lane.sv
// One lane of the activation datapath: bias add, ReLU, right shift, saturate.
module layer1_act_lane import layer1_pkg::*; #(
  parameter int LANE_W = LANE_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic [LANE_W-1:0] lane,
  input  logic [LANE_W-1:0] bias,
  output logic [OUT_W-1:0]  act
);

  logic [LANE_W:0] sum;
  logic [LANE_W:0] shifted;

  always_comb begin
    // One extra bit of headroom means the two's complement add cannot overflow.
    sum     = {lane[LANE_W-1], lane} + {bias[LANE_W-1], bias};
    shifted = '0;
    if (!sum[LANE_W]) begin
      shifted = sum >> SHIFT;
    end
    act = (|shifted[LANE_W:OUT_W]) ? '1 : shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/layer1_post.sv
// Captures a column of accumulator sums, activates all lanes in one cycle,
// then streams the activations out one lane per handshake.
module layer1_post import layer1_pkg::*; #(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    col_valid,
  output logic                    col_ready,
  input  logic [LANES*LANE_W-1:0] column,
  input  logic [LANE_W-1:0]       bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [3:0]              out_idx,
  output logic                    out_last,
  output logic                    overrun
);

  localparam logic [3:0] LAST_IDX = 4'(LANES - 1);

  state_t                  state_reg;
  state_t                  state_next;
  logic [LANES*LANE_W-1:0] column_reg;
  logic [LANE_W-1:0]       bias_reg;
  logic [OUT_W-1:0]        buf_reg [LANES];
  logic [OUT_W-1:0]        act [LANES];
  logic [3:0]              idx_reg;
  logic                    overrun_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      layer1_act_lane #(
        .LANE_W (LANE_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT)
      ) u_act (
        .lane (column_reg[gi*LANE_W +: LANE_W]),
        .bias (bias_reg),
        .act  (act[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (col_valid) state_next = PROC;
      PROC:    state_next = SEND;
      SEND:    if (out_ready && idx_reg == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    col_ready = (state_reg == IDLE);
    out_valid = (state_reg == SEND);
    out_idx   = idx_reg;
    out_data  = out_valid ? buf_reg[idx_reg] : '0;
    out_last  = out_valid && (idx_reg == LAST_IDX);
    overrun   = overrun_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      column_reg <= '0;
      bias_reg   <= '0;
    end else if (state_reg == IDLE && col_valid) begin
      column_reg <= column;
      bias_reg   <= bias;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (reset) begin
        buf_reg[i] <= '0;
      end else if (state_reg == PROC) begin
        buf_reg[i] <= act[i];
      end
    end
  end

  // Index wraps to 0 on the final transfer so it reads 0 while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (state_reg == PROC) begin
        idx_reg <= '0;
      end else if (state_reg == SEND && out_ready) begin
        idx_reg <= (idx_reg == LAST_IDX) ? 4'd0 : idx_reg + 4'd1;
      end
      if (col_valid && state_reg != IDLE) begin
        overrun_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer1_post.sv
// Directed and randomized checks of layer1_post against an integer model.
module tb_layer1_post;

  localparam int LANES  = 10;
  localparam int LANE_W = 16;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    col_valid;
  logic                    col_ready;
  logic [LANES*LANE_W-1:0] column;
  logic [LANE_W-1:0]       bias;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic [3:0]              out_idx;
  logic                    out_last;
  logic                    overrun;

  int   vectors     = 0;
  int   miscompares = 0;
  int   transfers   = 0;
  logic ovr_exp     = 1'b0;
  int   lane_v [LANES];
  int   bias_v;
  int   exp_v  [LANES];

  always #5 clk = ~clk;

  layer1_post #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .column    (column),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .overrun   (overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int act_model(input int l, input int b);
    int s;
    s = l + b;
    if (s < 0) return 0;
    s = s / (1 << SHIFT);
    if (s > (1 << OUT_W) - 1) return (1 << OUT_W) - 1;
    return s;
  endfunction

  task automatic model_all;
    for (int k = 0; k < LANES; k++) exp_v[k] = act_model(lane_v[k], bias_v);
  endtask

  task automatic randomize_column;
    logic signed [15:0] r16;
    for (int k = 0; k < LANES; k++) begin
      r16 = 16'($urandom);
      case ($urandom % 4)
        0:       lane_v[k] = int'(r16);
        1:       lane_v[k] = int'($urandom_range(0, 4200));
        2:       lane_v[k] = int'($urandom_range(0, 128)) - 64;
        default: lane_v[k] = ($urandom % 2 == 0) ? 32767 : -32768;
      endcase
    end
    bias_v = int'($urandom_range(0, 4000)) - 2000;
    model_all();
  endtask

  task automatic send;
    int n;
    n = 0;
    while (col_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("col_ready_timeout", 32'(n), 32'(0));
    for (int k = 0; k < LANES; k++) column[k*LANE_W +: LANE_W] = 16'(lane_v[k]);
    bias      = 16'(bias_v);
    col_valid = 1'b1;
    tick();
    col_valid = 1'b0;
    column    = {LANES{16'($urandom)}};
    chk("proc_out_valid", 32'(out_valid), 32'(0));
    chk("proc_col_ready", 32'(col_ready), 32'(0));
    tick();
    chk("first_out_valid", 32'(out_valid), 32'(1));
    chk("first_out_idx", 32'(out_idx), 32'(0));
  endtask

  // mode 0: always ready, 1: ready pattern 1-0-0-1, 2: random ready
  task automatic drain(input int mode, input int pulse_at, input int abort_at);
    int k;
    int c;
    k = 0;
    c = 0;
    while (k < LANES && c < 400) begin
      if (abort_at >= 0 && k == abort_at) begin
        reset     = 1'b1;
        col_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        reset     = 1'b0;
        col_valid = 1'b0;
        ovr_exp   = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_col_ready", 32'(col_ready), 32'(1));
        chk("abort_out_idx", 32'(out_idx), 32'(0));
        chk("abort_out_data", 32'(out_data), 32'(0));
        chk("abort_out_last", 32'(out_last), 32'(0));
        chk("abort_overrun", 32'(overrun), 32'(0));
        tick();
        chk("abort_still_idle", 32'(col_ready), 32'(1));
        chk("abort_no_stream", 32'(out_valid), 32'(0));
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: out_ready = 1'($urandom % 2);
      endcase
      chk("out_valid", 32'(out_valid), 32'(1));
      chk("out_idx", 32'(out_idx), 32'(k));
      chk("out_data", 32'(out_data), 32'(exp_v[k]));
      chk("out_last", 32'(out_last), 32'(k == LANES - 1));
      chk("col_ready_busy", 32'(col_ready), 32'(0));
      chk("overrun", 32'(overrun), 32'(ovr_exp));
      if (c == pulse_at) begin
        col_valid = 1'b1;
        column    = {LANES{16'($urandom)}};
        bias      = 16'($urandom);
      end
      tick();
      if (col_valid) begin
        ovr_exp   = 1'b1;
        col_valid = 1'b0;
      end
      if (out_ready) begin
        k++;
        transfers++;
      end
      c++;
    end
    out_ready = 1'b0;
    if (k < LANES) chk("drain_timeout", 32'(k), 32'(LANES));
    chk("end_out_valid", 32'(out_valid), 32'(0));
    chk("end_out_last", 32'(out_last), 32'(0));
    chk("end_col_ready", 32'(col_ready), 32'(1));
    chk("end_overrun", 32'(overrun), 32'(ovr_exp));
  endtask

  initial begin
    reset     = 1'b1;
    col_valid = 1'b0;
    out_ready = 1'b0;
    column    = '0;
    bias      = '0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_idx", 32'(out_idx), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    reset = 1'b0;
    tick();
    chk("rst_col_ready", 32'(col_ready), 32'(1));

    // Boundary lanes with known answers
    lane_v = '{100, -50, 0, 4095, 16, 15, -1, 32767, -32768, 200};
    exp_v  = '{6, 0, 0, 255, 1, 0, 0, 255, 0, 12};
    bias_v = 0;
    send();
    drain(0, -1, -1);

    for (int k = 0; k < LANES; k++) lane_v[k] = 1000;
    bias_v = -1000;
    model_all();
    send();
    drain(0, -1, -1);
    bias_v = 24;
    model_all();
    send();
    drain(0, -1, -1);

    randomize_column();
    send();
    drain(1, -1, -1);

    // Column offered mid-stream must be dropped and flag overrun
    randomize_column();
    send();
    drain(2, 3, -1);
    randomize_column();
    send();
    drain(1, -1, -1);

    randomize_column();
    send();
    drain(0, -1, 4);
    randomize_column();
    send();
    drain(0, -1, -1);

    transfers = 0;
    for (int r = 0; r < 2; r++) begin
      randomize_column();
      send();
      drain(0, -1, -1);
    end
    chk("back_to_back_transfers", 32'(transfers), 32'(2 * LANES));

    for (int r = 0; r < 6; r++) begin
      randomize_column();
      send();
      drain(2, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
